// File: rtl/ifu.sv
// ----------------------------------------------------------------------------
// ifu - instruction fetch unit
//
// Owns the program counter and fetches one instruction at a time from
// instruction memory (single outstanding request). The fetched word is held
// in a one-entry output buffer that feeds the if_id register. The downstream
// stage can stall the buffer (hold_i) and execute can redirect the fetch
// stream (jump_en_i). While the buffer is empty a NOP is presented.
//
// Ports:
//   clk, rst_n        core clock; asynchronous active-low reset
//   jump_en_i         redirect pulse from ex (highest priority)
//   jump_addr_i       redirect target, low two bits forced to zero
//   hold_i            downstream stall, buffered instruction not consumed
//   imem_req_o        one-cycle read request to instruction memory
//   imem_addr_o       request address (the current pc)
//   imem_rvalid_i     read data valid, one or more cycles after the request
//   imem_rdata_i      instruction word returned with imem_rvalid_i
//   inst_o            buffered instruction, NOP when inst_valid_o is low
//   inst_addr_o       address of inst_o, zero when inst_valid_o is low
//   inst_valid_o      buffered instruction valid
// ----------------------------------------------------------------------------
module ifu #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        discard, discard_next;
  logic        inst_valid_next;
  logic [31:0] inst_next;
  logic [31:0] inst_addr_next;
  logic        consume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_ADDR;
      discard      <= 1'b0;
      inst_valid_o <= 1'b0;
      inst_o       <= NOP;
      inst_addr_o  <= 32'h0000_0000;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      discard      <= discard_next;
      inst_valid_o <= inst_valid_next;
      inst_o       <= inst_next;
      inst_addr_o  <= inst_addr_next;
    end
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    discard_next    = discard;
    inst_valid_next = inst_valid_o;
    inst_next       = inst_o;
    inst_addr_next  = inst_addr_o;
    imem_req_o      = 1'b0;
    imem_addr_o     = pc;

    consume = inst_valid_o && !hold_i;

    // A consumed buffer empties unless the same edge refills it below.
    if (consume) begin
      inst_valid_next = 1'b0;
      inst_next       = NOP;
      inst_addr_next  = 32'h0000_0000;
    end

    case (state)
      IDLE: begin
        // Request only when the buffer is free at this edge; the response
        // can then always be accepted without backpressure. rst_n keeps the
        // request low while reset is held.
        imem_req_o = rst_n && !jump_en_i && (!inst_valid_o || consume);
        if (imem_req_o) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_next   = IDLE;
          discard_next = 1'b0;
          if (!discard && !jump_en_i) begin
            inst_valid_next = 1'b1;
            inst_next       = imem_rdata_i;
            inst_addr_next  = pc;
            pc_next         = pc + 32'd4;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Redirect overrides stall, refill and the pending response.
    if (jump_en_i) begin
      pc_next         = jump_addr_i & 32'hFFFF_FFFC;
      inst_valid_next = 1'b0;
      inst_next       = NOP;
      inst_addr_next  = 32'h0000_0000;
      // Response still in flight: remember to drop it when it lands.
      if (state == WAIT && !imem_rvalid_i) begin
        discard_next = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifu.sv
// ----------------------------------------------------------------------------
// tb_ifu - self-checking bench for ifu
//
// A memory model answers each request after a programmable latency with
// addr ^ 32'hA5A5_0000. A monitor keeps a reference model of the fetch stream
// (next fetch address, queue of live fetched items) and compares the DUT's
// request and buffer outputs every cycle. A directed sequence covers the
// documented timing cases, followed by randomized hold / jump / latency /
// reset stimulus.
// ----------------------------------------------------------------------------
module tb_ifu;

  localparam logic [31:0] RA  = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  ifu #(.RESET_ADDR(RA)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .hold_i       (hold_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_consumed = 0;
  int lat = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Instruction memory: captures a request at the falling edge, answers
  // 'lat' cycles later. Forgets a pending request across reset.
  // --------------------------------------------------------------------------
  initial begin
    bit          pend;
    int          cnt;
    logic [31:0] paddr;
    pend = 0; cnt = 0; paddr = '0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req_o) begin
        pend  = 1;
        paddr = imem_addr_o;
        cnt   = lat;
      end
      @(posedge clk);
      #1;
      imem_rvalid_i = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = paddr ^ KEY;
          pend = 0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard / reference model
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          arrived;
  } item_t;

  item_t       exp_q[$];
  logic [31:0] model_pc = RA;
  bit          outstanding = 0;

  always @(negedge clk) begin
    bit exp_v;
    bit exp_req;
    item_t it;
    if (!rst_n) begin
      exp_q.delete();
      model_pc    = RA;
      outstanding = 0;
      check("rst_req", {31'b0, imem_req_o}, 32'd0);
      check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
      check("rst_inst", inst_o, NOP);
      check("rst_iaddr", inst_addr_o, 32'd0);
      check("rst_imem_addr", imem_addr_o, RA);
    end else begin
      // Buffer contents: the oldest live fetch once its data has returned.
      exp_v = (exp_q.size() > 0) && exp_q[0].arrived;
      check("buf_valid", {31'b0, inst_valid_o}, {31'b0, exp_v});
      if (inst_valid_o && exp_q.size() > 0) begin
        check("buf_addr", inst_addr_o, exp_q[0].addr);
        check("buf_inst", inst_o, exp_q[0].data);
      end else if (!inst_valid_o) begin
        check("nop_inst", inst_o, NOP);
        check("nop_addr", inst_addr_o, 32'd0);
      end

      // Fetch whenever nothing is in flight, no redirect, and the buffer is
      // empty or being drained this cycle.
      exp_req = !jump_en_i && !outstanding && (!exp_v || !hold_i);
      check("req", {31'b0, imem_req_o}, {31'b0, exp_req});
      if (imem_req_o) begin
        check("req_addr", imem_addr_o, model_pc);
        it.addr = model_pc;
        it.data = model_pc ^ KEY;
        it.arrived = 0;
        exp_q.push_back(it);
        model_pc = model_pc + 32'd4;
        outstanding = 1;
      end

      if (imem_rvalid_i) begin
        check("rvalid_outstanding", {31'b0, outstanding}, 32'd1);
        outstanding = 0;
        if (!jump_en_i) begin
          for (int i = 0; i < exp_q.size(); i++) begin
            if (!exp_q[i].arrived) begin
              exp_q[i].arrived = 1;
              break;
            end
          end
        end
      end

      if (jump_en_i) begin
        exp_q.delete();
        model_pc = {jump_addr_i[31:2], 2'b00};
      end else if (exp_v && !hold_i) begin
        void'(exp_q.pop_front());
        n_consumed++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a request; n = cycles elapsed from the current cycle.
  task automatic wait_req(output int n);
    n = 0;
    @(negedge clk);
    while (!imem_req_o && n < 20) begin
      step();
      n++;
      @(negedge clk);
    end
  endtask

  bit          exp_req_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit          exp_val_seq [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] exp_adr_seq [4] = '{32'h100, 32'h0, 32'h104, 32'h0};

  initial begin
    int n;
    rst_n       = 1'b0;
    jump_en_i   = 1'b0;
    jump_addr_i = '0;
    hold_i      = 1'b0;
    lat         = 1;
    repeat (3) step();

    // Reset release with 1-cycle memory: request every 2 cycles.
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("seq_req_c%0d", c), {31'b0, imem_req_o}, {31'b0, exp_req_seq[c]});
      check($sformatf("seq_valid_c%0d", c), {31'b0, inst_valid_o}, {31'b0, exp_val_seq[c]});
      if (exp_req_seq[c]) check($sformatf("seq_addr_c%0d", c), imem_addr_o, exp_adr_seq[c]);
      if (exp_val_seq[c]) check($sformatf("seq_iaddr_c%0d", c), inst_addr_o, 32'h100);
      step();
    end

    // Hold for 5 cycles with 0x104 buffered.
    hold_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, inst_valid_o}, 32'd1);
      check("hold_iaddr", inst_addr_o, 32'h104);
      check("hold_inst", inst_o, 32'h104 ^ KEY);
      check("hold_req", {31'b0, imem_req_o}, 32'd0);
      step();
    end
    hold_i = 1'b0;
    lat    = 3;
    @(negedge clk);
    check("unhold_req", {31'b0, imem_req_o}, 32'd1);
    check("unhold_addr", imem_addr_o, 32'h108);
    step();

    // Jump while waiting on a 3-cycle response.
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h0000_2002;
    @(negedge clk);
    check("jw_req", {31'b0, imem_req_o}, 32'd0);
    check("jw_valid", {31'b0, inst_valid_o}, 32'd0);
    step();
    jump_en_i = 1'b0;
    wait_req(n);
    check("jw_req_delay", n, 32'd2);
    check("jw_req_addr", imem_addr_o, 32'h2000);
    check("jw_valid_after", {31'b0, inst_valid_o}, 32'd0);
    step();
    wait_req(n);
    check("jw_next_delay", n, 32'd3);
    check("jw_next_addr", imem_addr_o, 32'h2004);

    // Jump in the same cycle as the response (0x2004 returns 3 cycles on).
    step();
    step();
    step();
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h0000_3000;
    lat         = 1;
    @(negedge clk);
    check("jr_req", {31'b0, imem_req_o}, 32'd0);
    step();
    jump_en_i = 1'b0;
    @(negedge clk);
    check("jr_valid", {31'b0, inst_valid_o}, 32'd0);
    check("jr_req_next", {31'b0, imem_req_o}, 32'd1);
    check("jr_addr_next", imem_addr_o, 32'h3000);

    // PC wrap: fetch 0xFFFF_FFFC, next request is 0.
    step();
    jump_en_i   = 1'b1;
    jump_addr_i = 32'hFFFF_FFFE;
    step();
    jump_en_i = 1'b0;
    @(negedge clk);
    check("wrap_req", {31'b0, imem_req_o}, 32'd1);
    check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    step();
    step();
    @(negedge clk);
    check("wrap_iaddr", inst_addr_o, 32'hFFFF_FFFC);
    check("wrap_next_req", {31'b0, imem_req_o}, 32'd1);
    check("wrap_next_addr", imem_addr_o, 32'h0000_0000);

    // Asynchronous reset with a valid buffered instruction.
    step();
    step();
    hold_i = 1'b1;
    #2;
    check("ar_pre_valid", {31'b0, inst_valid_o}, 32'd1);
    check("ar_pre_iaddr", inst_addr_o, 32'h0);
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'b0, inst_valid_o}, 32'd0);
    check("ar_inst", inst_o, NOP);
    check("ar_iaddr", inst_addr_o, 32'd0);
    check("ar_req", {31'b0, imem_req_o}, 32'd0);
    check("ar_imem_addr", imem_addr_o, RA);
    step();
    step();
    rst_n  = 1'b1;
    hold_i = 1'b0;
    @(negedge clk);
    check("ar_restart_req", {31'b0, imem_req_o}, 32'd1);
    check("ar_restart_addr", imem_addr_o, RA);
    step();

    // Randomized phase; the monitor checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 600 == 0) begin
        rst_n     = 1'b0;
        jump_en_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
      end
      hold_i    = ($urandom % 4 == 0);
      lat       = $urandom_range(1, 4);
      jump_en_i = ($urandom % 16 == 0);
      if ($urandom % 4 == 0) jump_addr_i = 32'hFFFF_FFF0 | ($urandom % 16);
      else                   jump_addr_i = $urandom;
      step();
    end
    jump_en_i = 1'b0;
    hold_i    = 1'b0;
    repeat (10) step();
    check("progress", {31'b0, n_consumed > 300}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t, required < 2000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
